// File: rtl/seg7_scan_if.sv
// Display-bus snoop interface: the active-low seg/an bus and clear in, capture results out.
interface seg7_scan_if;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        clear;
    logic        cap_valid;
    logic [1:0]  cap_pos;
    logic [3:0]  cap_bcd;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  seen;
    logic        frame_valid;
    logic        err;

    modport master (
        output seg, an, clear,
        input  cap_valid, cap_pos, cap_bcd, digits, dp, blank, seen, frame_valid, err
    );

    modport slave (
        input  seg, an, clear,
        output cap_valid, cap_pos, cap_bcd, digits, dp, blank, seen, frame_valid, err
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// Snoops a multiplexed active-low 7-segment bus, filters each stable digit pattern and
// recovers per-position BCD, decimal point and blank state.
module seg7_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    seg7_scan_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Returns {illegal, blank, bcd} for segments a..g (0 = lit).
    function automatic logic [5:0] decode_seg(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b0000001: r = {1'b0, 1'b0, 4'd0};
            7'b1001111: r = {1'b0, 1'b0, 4'd1};
            7'b0010010: r = {1'b0, 1'b0, 4'd2};
            7'b0000110: r = {1'b0, 1'b0, 4'd3};
            7'b1001100: r = {1'b0, 1'b0, 4'd4};
            7'b0100100: r = {1'b0, 1'b0, 4'd5};
            7'b0100000: r = {1'b0, 1'b0, 4'd6};
            7'b0001111: r = {1'b0, 1'b0, 4'd7};
            7'b0000000: r = {1'b0, 1'b0, 4'd8};
            7'b0000100: r = {1'b0, 1'b0, 4'd9};
            7'b1111111: r = {1'b0, 1'b1, 4'd0};
            default:    r = {1'b1, 1'b0, 4'hF};
        endcase
        return r;
    endfunction

    // Returns {not_one_hot, position} for an active-low anode vector.
    function automatic logic [2:0] anode_pos(input logic [3:0] a);
        logic [2:0] r;
        case (a)
            4'b1110: r = {1'b0, 2'd0};
            4'b1101: r = {1'b0, 2'd1};
            4'b1011: r = {1'b0, 2'd2};
            4'b0111: r = {1'b0, 2'd3};
            default: r = {1'b1, 2'd0};
        endcase
        return r;
    endfunction

    state_t      state_q;
    logic [11:0] samp_q, samp_d;
    logic [7:0]  count_q, count_d;
    logic        cap_valid_q, cap_valid_d;
    logic [1:0]  cap_pos_q, cap_pos_d;
    logic [3:0]  cap_bcd_q, cap_bcd_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_valid_q, frame_valid_d;
    logic        err_q, err_d;

    logic [5:0]  dec_s;
    logic [2:0]  pos_info_s;
    logic [1:0]  pos_s;
    logic [3:0]  samp_an_s;
    logic        capture_s, write_s, multi_s;
    logic [3:0]  seen_set_s;
    logic        err_set_s;

    // Run-length counter over the registered {seg,an} sample.
    always_comb begin
        samp_d = {bus.seg, bus.an};
        if (samp_d != samp_q) begin
            count_d = 8'd1;
        end else if (count_q < STABLE_C) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Capture decode and bookkeeping for digits, seen, frame and error.
    always_comb begin
        samp_an_s  = samp_q[3:0];
        dec_s      = decode_seg(samp_q[11:5]);
        pos_info_s = anode_pos(samp_an_s);
        multi_s    = pos_info_s[2];
        pos_s      = pos_info_s[1:0];
        capture_s  = (state_q == ST_TRACK) && (samp_an_s != AN_OFF) && (count_q == STABLE_C);
        write_s    = capture_s && !multi_s;

        digits_d      = digits_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        cap_pos_d     = cap_pos_q;
        cap_bcd_d     = cap_bcd_q;
        cap_valid_d   = 1'b0;
        frame_valid_d = 1'b0;
        seen_set_s    = seen_q;
        seen_d        = seen_q;
        err_d         = err_q;

        if (write_s) begin
            digits_d[{pos_s, 2'b00} +: 4] = dec_s[3:0];
            dp_d[pos_s]    = ~samp_q[4];
            blank_d[pos_s] = dec_s[4];
            cap_pos_d      = pos_s;
            cap_bcd_d      = dec_s[3:0];
            cap_valid_d    = 1'b1;
            seen_set_s     = seen_q | (4'b0001 << pos_s);
        end else begin
            seen_set_s     = seen_q;
        end

        err_set_s = err_q | (capture_s & multi_s) | (write_s & dec_s[5]);

        // Clear overrides seen/err and masks the frame pulse even on a capture edge.
        if (bus.clear) begin
            seen_d = 4'b0000;
            err_d  = 1'b0;
        end else if (seen_set_s == 4'b1111) begin
            seen_d        = 4'b0000;
            frame_valid_d = 1'b1;
            err_d         = err_set_s;
        end else begin
            seen_d = seen_set_s;
            err_d  = err_set_s;
        end
    end

    // Sample/track/hold state machine and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            samp_q        <= {8'hFF, 4'hF};
            count_q       <= 8'd0;
            cap_valid_q   <= 1'b0;
            cap_pos_q     <= 2'd0;
            cap_bcd_q     <= 4'd0;
            digits_q      <= 16'h0000;
            dp_q          <= 4'b0000;
            blank_q       <= 4'b0000;
            seen_q        <= 4'b0000;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            samp_q        <= samp_d;
            count_q       <= count_d;
            cap_valid_q   <= cap_valid_d;
            cap_pos_q     <= cap_pos_d;
            cap_bcd_q     <= cap_bcd_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (samp_an_s != AN_OFF) state_q <= ST_TRACK;
                    else                     state_q <= ST_IDLE;
                end
                ST_TRACK: begin
                    if (samp_an_s == AN_OFF)       state_q <= ST_IDLE;
                    else if (count_q == STABLE_C)  state_q <= ST_HOLD;
                    else                           state_q <= ST_TRACK;
                end
                ST_HOLD: begin
                    // A count of one means the sample just changed.
                    if (count_q == 8'd1) begin
                        if (samp_an_s == AN_OFF) state_q <= ST_IDLE;
                        else                     state_q <= ST_TRACK;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cap_valid   = cap_valid_q;
    assign bus.cap_pos     = cap_pos_q;
    assign bus.cap_bcd     = cap_bcd_q;
    assign bus.digits      = digits_q;
    assign bus.dp          = dp_q;
    assign bus.blank       = blank_q;
    assign bus.seen        = seen_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with hand-computed expectations.
module tb_seg7_scan_capture;

    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    seg7_scan_if bus ();

    seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] s, input logic dpn, input logic [3:0] a);
        bus.seg = {s, dpn};
        bus.an  = a;
    endtask

    task automatic test_reset();
        logic [36:0] all_out;
        rst = 1'b1;
        bus.clear = 1'b0;
        drive(SB, 1'b1, 4'b1111);
        tick();
        tick();
        rst = 1'b0;
        tick();
        all_out = {bus.cap_valid, bus.cap_pos, bus.cap_bcd, bus.digits, bus.dp, bus.blank,
                   bus.seen, bus.frame_valid, bus.err};
        tests_run++;
        if (all_out !== 37'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_single_capture();
        int caps = 0;
        drive(S2, 1'b1, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            tick();
            caps += int'(bus.cap_valid);
        end
        tests_run++;
        if (caps !== 0) begin
            tests_failed++;
            $display("FAIL single_early_pulse: got %0d pulses expected 0", caps);
        end
        tick();
        tests_run++;
        if ({bus.cap_valid, bus.cap_pos, bus.cap_bcd} !== {1'b1, 2'd0, 4'd2}) begin
            tests_failed++;
            $display("FAIL single_capture: got v=%b pos=%0d bcd=%h expected v=1 pos=0 bcd=2",
                     bus.cap_valid, bus.cap_pos, bus.cap_bcd);
        end
        tests_run++;
        if ({bus.digits[3:0], bus.dp[0], bus.blank[0], bus.seen} !== {4'd2, 1'b0, 1'b0, 4'b0001}) begin
            tests_failed++;
            $display("FAIL single_state: got d=%h dp=%b bl=%b seen=%b expected d=2 dp=0 bl=0 seen=0001",
                     bus.digits[3:0], bus.dp[0], bus.blank[0], bus.seen);
        end
        caps = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            caps += int'(bus.cap_valid);
        end
        tests_run++;
        if (caps !== 0) begin
            tests_failed++;
            $display("FAIL single_repeat_pulse: got %0d pulses expected 0", caps);
        end
    endtask

    task automatic test_frame_scan();
        logic [3:0] an_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_tab [4] = '{S7, S3, S9, SB};
        int   caps   = 0;
        int   frames = 0;
        logic frame_with_last = 1'b0;
        for (int p = 0; p < 4; p++) begin
            drive(seg_tab[p], 1'b1, an_tab[p]);
            for (int c = 0; c < 6; c++) begin
                tick();
                caps += int'(bus.cap_valid);
                if (bus.frame_valid) begin
                    frames++;
                    frame_with_last = (p == 3) && bus.cap_valid;
                end
            end
        end
        tests_run++;
        if (caps !== 4 || frames !== 1 || frame_with_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_pulses: got caps=%0d frames=%0d with_last=%b expected 4 1 1",
                     caps, frames, frame_with_last);
        end
        tests_run++;
        if ({bus.digits, bus.blank, bus.seen} !== {16'h0937, 4'b1000, 4'b0000}) begin
            tests_failed++;
            $display("FAIL frame_state: got digits=%h blank=%b seen=%b expected 0937 1000 0000",
                     bus.digits, bus.blank, bus.seen);
        end
    endtask

    task automatic test_glitch_filter();
        int caps = 0;
        for (int t = 0; t < 4; t++) begin
            drive((t % 2 == 0) ? S1 : S4, 1'b1, 4'b1101);
            for (int c = 0; c < 3; c++) begin
                tick();
                caps += int'(bus.cap_valid);
            end
        end
        tests_run++;
        if (caps !== 0) begin
            tests_failed++;
            $display("FAIL glitch_no_capture: got %0d pulses expected 0", caps);
        end
        drive(S5, 1'b1, 4'b1101);
        for (int c = 0; c < 10; c++) begin
            tick();
            caps += int'(bus.cap_valid);
        end
        tests_run++;
        if (caps !== 1 || bus.cap_bcd !== 4'd5 || bus.cap_pos !== 2'd1 || bus.digits !== 16'h0957) begin
            tests_failed++;
            $display("FAIL glitch_stable: got caps=%0d bcd=%h pos=%0d digits=%h expected 1 5 1 0957",
                     caps, bus.cap_bcd, bus.cap_pos, bus.digits);
        end
    endtask

    task automatic test_multi_hot();
        int caps = 0;
        drive(S8, 1'b1, 4'b1100);
        for (int c = 0; c < 6; c++) begin
            tick();
            caps += int'(bus.cap_valid);
        end
        tests_run++;
        if (caps !== 0 || bus.err !== 1'b1 || bus.digits !== 16'h0957) begin
            tests_failed++;
            $display("FAIL multi_hot: got caps=%0d err=%b digits=%h expected 0 1 0957",
                     caps, bus.err, bus.digits);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL multi_hot_sticky: got err=%b expected 1", bus.err);
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tests_run++;
        if (bus.err !== 1'b0 || bus.seen !== 4'b0000) begin
            tests_failed++;
            $display("FAIL clear_err: got err=%b seen=%b expected 0 0000", bus.err, bus.seen);
        end
        tick();
        tick();
        tests_run++;
        if (bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_hold: got err=%b expected 0", bus.err);
        end
    endtask

    task automatic test_illegal_and_reset();
        int caps = 0;
        logic [36:0] all_out;
        drive(7'b1111110, 1'b0, 4'b0111);
        for (int c = 0; c < 6; c++) begin
            tick();
            caps += int'(bus.cap_valid);
        end
        tests_run++;
        if (caps !== 1 || bus.cap_bcd !== 4'hF || bus.digits[15:12] !== 4'hF || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_code: got caps=%0d bcd=%h d3=%h err=%b expected 1 F F 1",
                     caps, bus.cap_bcd, bus.digits[15:12], bus.err);
        end
        tests_run++;
        if (bus.dp[3] !== 1'b1 || bus.blank[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_dp_blank: got dp3=%b bl3=%b expected 1 0", bus.dp[3], bus.blank[3]);
        end
        drive(S8, 1'b1, 4'b0111);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        all_out = {bus.cap_valid, bus.cap_pos, bus.cap_bcd, bus.digits, bus.dp, bus.blank,
                   bus.seen, bus.frame_valid, bus.err};
        tests_run++;
        if (all_out !== 37'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected 0", all_out);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_clear_coincident();
        logic [3:0] an_tab [3]  = '{4'b1110, 4'b1101, 4'b1011};
        logic [6:0] seg_tab [3] = '{S1, S2, S3};
        for (int p = 0; p < 3; p++) begin
            drive(seg_tab[p], 1'b1, an_tab[p]);
            for (int c = 0; c < 6; c++) tick();
        end
        tests_run++;
        if (bus.seen !== 4'b0111 || bus.digits !== 16'h0321) begin
            tests_failed++;
            $display("FAIL pre_clear_state: got seen=%b digits=%h expected 0111 0321",
                     bus.seen, bus.digits);
        end
        drive(S4, 1'b1, 4'b0111);
        for (int c = 0; c < 4; c++) tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tests_run++;
        if ({bus.cap_valid, bus.frame_valid, bus.seen, bus.digits[15:12]} !== {1'b1, 1'b0, 4'b0000, 4'd4}) begin
            tests_failed++;
            $display("FAIL clear_coincident: got v=%b fv=%b seen=%b d3=%h expected 1 0 0000 4",
                     bus.cap_valid, bus.frame_valid, bus.seen, bus.digits[15:12]);
        end
        tick();
        tests_run++;
        if (bus.frame_valid !== 1'b0 || bus.seen !== 4'b0000 || bus.cap_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_after: got fv=%b seen=%b v=%b expected 0 0000 0",
                     bus.frame_valid, bus.seen, bus.cap_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_frame_scan();
        test_glitch_filter();
        test_multi_hot();
        test_illegal_and_reset();
        test_clear_coincident();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
